// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state type and byte-select width derivation for wb_req_master.
package wb_pkg;
  localparam int ByteBits = 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} wb_master_state_e;
  function automatic int sel_width(input int data_width);
    return data_width / ByteBits;
  endfunction
endpackage

// File: rtl/wb_req_master_if.sv
// wb_req_master_if: CPU request/response port plus Wishbone B4 pipelined master signals.
interface wb_req_master_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 30
);
  localparam int SelWidth = wb_pkg::sel_width(DataWidth);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_data_i;
  logic [SelWidth-1:0]  req_sel_i;
  logic                 req_we_i;
  logic                 rsp_valid_o;
  logic [DataWidth-1:0] rsp_data_o;
  logic                 rsp_err_o;
  logic [DataWidth-1:0] wb_data_i;
  logic                 wb_ack_i;
  logic                 wb_stall_i;
  logic                 wb_err_i;
  logic [DataWidth-1:0] wb_data_o;
  logic [AddrWidth-1:0] wb_addr_o;
  logic [SelWidth-1:0]  wb_sel_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  modport master (
    input  req_valid_i, req_addr_i, req_data_i, req_sel_i, req_we_i,
           wb_data_i, wb_ack_i, wb_stall_i, wb_err_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           wb_data_o, wb_addr_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o
  );
  modport slave (
    output req_valid_i, req_addr_i, req_data_i, req_sel_i, req_we_i,
           wb_data_i, wb_ack_i, wb_stall_i, wb_err_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           wb_data_o, wb_addr_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o
  );
endinterface

// File: rtl/wb_req_master.sv
// wb_req_master: single-outstanding valid/ready to Wishbone B4 pipelined master bridge.
// Define WB_TIMEOUT_EN to abort a WAIT that lasts TimeoutCycles cycles with an error response.
module wb_req_master
  import wb_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 30,
  parameter int TimeoutCycles = 255
) (
  input logic clk_i,
  input logic rst_i,
  wb_req_master_if.master bus
);
  if (DataWidth % 8 != 0 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_param
    $error("wb_req_master: invalid parameters");
  end
  wb_master_state_e     state_q, state_d;
  logic                 accept, zero_wr, load, done, abort, rsp_fire, rsp_err_d;
  logic [DataWidth-1:0] rsp_data_d;
`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != WAIT) cnt_q <= '0;
    else cnt_q <= cnt_q + 16'd1;
  end
  assign abort = state_q == WAIT && cnt_q == 16'(TimeoutCycles - 1) && !(bus.wb_ack_i || bus.wb_err_i);
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      bus.req_ready_o <= 1'b1;
      bus.wb_cyc_o    <= 1'b0;
      bus.wb_stb_o    <= 1'b0;
      bus.wb_we_o     <= 1'b0;
      bus.wb_addr_o   <= '0;
      bus.wb_data_o   <= '0;
      bus.wb_sel_o    <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_data_o  <= '0;
    end else begin
      state_q         <= state_d;
      bus.req_ready_o <= state_d == IDLE;
      bus.wb_cyc_o    <= state_d != IDLE;
      bus.wb_stb_o    <= state_d == REQ;
      bus.rsp_valid_o <= rsp_fire;
      if (load) begin
        bus.wb_we_o   <= bus.req_we_i;
        bus.wb_addr_o <= bus.req_addr_i;
        bus.wb_data_o <= bus.req_data_i;
        bus.wb_sel_o  <= bus.req_sel_i;
      end
      if (rsp_fire) begin
        bus.rsp_err_o  <= rsp_err_d;
        bus.rsp_data_o <= rsp_data_d;
      end
    end
  end
  always_comb begin
    accept  = state_q == IDLE && bus.req_valid_i;
    zero_wr = bus.req_we_i && ~|bus.req_sel_i;
    done    = state_q == WAIT && (bus.wb_ack_i || bus.wb_err_i || abort);
    state_d = state_q == IDLE ? ((accept && !zero_wr) ? REQ : IDLE)
            : state_q == REQ  ? (bus.wb_stall_i ? REQ : WAIT)
            : state_q == WAIT ? (done ? IDLE : WAIT)
            : IDLE;
  end
  // A zero-select write is answered with an error without ever touching the bus.
  always_comb begin
    load       = accept && !zero_wr;
    rsp_fire   = (accept && zero_wr) || done;
    rsp_err_d  = (accept && zero_wr) || bus.wb_err_i || abort;
    rsp_data_d = (done && bus.wb_ack_i && !bus.wb_err_i && !bus.wb_we_o) ? bus.wb_data_i : '0;
  end
endmodule

// File: doc/wb_req_master.md
Name: wb_req_master

Overview:
- Bridges a simple valid/ready CPU-side request port onto a Wishbone B4 pipelined master bus.
- Sits directly upstream of the bus; its wb_* outputs are the signals checked by the bus master property bench.
- Supports one outstanding transaction at a time.
- Returns a single-cycle response pulse carrying read data or an error flag.

Parameters:
- DataWidth, 32, bus data width; must be a multiple of 8.
- AddrWidth, 30, word address width.
- SelWidth, DataWidth/8, byte-select width (localparam).
- TimeoutCycles, 255, WAIT-state cycles before abort; used only with WB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  AddrWidth  request word address.
- req_data_i  in  DataWidth  write data.
- req_sel_i  in  SelWidth  byte selects.
- req_we_i  in  1  1=write, 0=read.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_data_o  out  DataWidth  read data.
- rsp_err_o  out  1  response is an error.
- wb_data_i  in  DataWidth  slave read data.
- wb_ack_i  in  1  slave ack.
- wb_stall_i  in  1  slave stall.
- wb_err_i  in  1  slave error.
- wb_data_o  out  DataWidth  write data.
- wb_addr_o  out  AddrWidth  address.
- wb_sel_o  out  SelWidth  byte selects.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset rst_i is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - wb_cyc_o, wb_stb_o, wb_we_o = 0.
  - wb_addr_o, wb_data_o, wb_sel_o = 0.
  - rsp_valid_o, rsp_err_o = 0; rsp_data_o = 0.
  - req_ready_o = 1 from the first cycle after reset.
  - State = IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr/data/sel/we into the wb_* registers.
  - Next cycle: cyc=1, stb=1, state=REQ, req_ready_o=0.
  - Latency from accept to stb is 1 cycle.
- Zero-select write (req_we_i=1 and req_sel_i==0):
  - Accepted, but no bus cycle is issued.
  - Next cycle: rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0; state stays IDLE.
- REQ:
  - While wb_stall_i=1, stb stays 1 and addr/we/sel/data hold bit-stable.
  - On wb_stall_i=0, the strobe is accepted that edge.
  - Next cycle: stb=0, cyc=1, state=WAIT.
  - ack/err during REQ are ignored; slaves must not ack before acceptance.
- WAIT:
  - wb_ack_i → next cycle: cyc=0, rsp_valid_o=1, rsp_data_o=wb_data_i as sampled (reads; 0 for writes), rsp_err_o=0, req_ready_o=1, state=IDLE.
  - wb_err_i → same as ack but rsp_err_o=1, rsp_data_o=0.
  - ack and err asserted together → treated as err.
- Back-to-back: a new request may be accepted in the cycle rsp_valid_o pulses; its stb rises one cycle later. cyc drops for at least one cycle between transactions.
- wb_stb_o=1 only while wb_cyc_o=1. Write strobes always have sel≠0.
- rsp_valid_o lasts exactly 1 cycle. rsp_data_o/rsp_err_o hold until the next response.
- Reset mid-transaction: cyc/stb drop the next edge; no response is produced; the request is lost.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - 8–16-bit counter, cleared on entering WAIT, increments each WAIT cycle.
  - When it reaches TimeoutCycles without ack/err: cyc=0, rsp_valid_o=1, rsp_err_o=1, state=IDLE.
  - A late ack after abort is ignored.
- Undefined:
  - No counter logic.
  - WAIT persists indefinitely.
  - TimeoutCycles has no effect.

Decomposition:
- Package wb_pkg:
  - typedef enum logic [1:0] wb_master_state_e {IDLE, REQ, WAIT}.
  - Helper localparam for SelWidth derivation.
- The bridge itself is a single module; no sub-module is needed.
- Timeout counter is inline under the macro. A separate wb_timeout_counter is not justified at this size.

Test Plan:
- Read, no stall: req addr=0x10 at cycle 0; stb cycle 1; ack cycle 2 with data 0xDEADBEEF → rsp_valid=1 cycle 3, rsp_data=0xDEADBEEF, rsp_err=0, cyc=0 cycle 3.
- Write, 3-cycle stall: req we=1, sel=0xF, data=0x12345678 → stb, addr, data, sel held identical for 4 cycles until stall=0; ack → rsp_err=0.
- Error: read, wb_err_i in WAIT → rsp_valid=1, rsp_err=1, rsp_data=0; next request accepted the same cycle.
- Zero-sel write: we=1, sel=0 → no cyc/stb ever asserted; rsp_err=1 the next cycle.
- Reset mid-WAIT: rst_i=1 while cyc=1 → cyc=stb=0 next cycle, no rsp_valid, req_ready=1 after release.
- WB_TIMEOUT_EN, TimeoutCycles=4: no ack → rsp_err=1 after 4 WAIT cycles; an ack 2 cycles later produces no response.
